// File: rtl/scorpion_param.sv
// scorpion_param: danger-reaction FSM that retreats N_RETREAT times, then attacks, darts and recovers.
// State durations are counted in prescaled ticks; a long calm spell in SENSE clears the retreat count.
module scorpion_param #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int N_RETREAT = 2,
    parameter int RETREAT_T = 1,
    parameter int WAIT_T    = 1,
    parameter int ATTACK_T  = 1,
    parameter int DART_T    = 1,
    parameter int RECOVER_T = 1,
    parameter int CALM_T    = 10,
    parameter int TW        = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       danger,
    output logic [3:0] out_state,
    output logic [3:0] round,
    output logic       back,
    output logic       sting,
    output logic       busy
);
    typedef enum logic [3:0] {
        SENSE   = 4'd0,
        RETREAT = 4'd1,
        WAIT    = 4'd2,
        ATTACK  = 4'd3,
        DART    = 4'd4,
        RECOVER = 4'd5
    } state_t;

    localparam logic [TW-1:0] TD = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] CT = TW'(CALM_T);
    localparam logic [3:0]    NR = 4'(N_RETREAT);

    state_t        state, next;
    logic          s1, d_s, tick, done, calm_hit;
    logic [TW-1:0] pre, tcnt, calm, dur;

    assign tick     = pre == TD;
    assign dur      = state == RETREAT ? TW'(RETREAT_T) :
                      state == WAIT    ? TW'(WAIT_T)    :
                      state == ATTACK  ? TW'(ATTACK_T)  :
                      state == DART    ? TW'(DART_T)    : TW'(RECOVER_T);
    assign done     = tick && tcnt == dur - TW'(1);
    assign calm_hit = CALM_T > 0 && tick && calm == CT - TW'(1);

    always_comb begin
        next = SENSE;
        case (state)
            SENSE:   next = !d_s ? SENSE : (round < NR) ? RETREAT : ATTACK;
            RETREAT: next = done ? WAIT    : RETREAT;
            WAIT:    next = done ? SENSE   : WAIT;
            ATTACK:  next = done ? DART    : ATTACK;
            DART:    next = done ? RECOVER : DART;
            RECOVER: next = done ? SENSE   : RECOVER;
            default: next = SENSE;
        endcase
    end

    // danger wins over a calm clear landing on the same tick: the increment branch comes first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SENSE;
            round <= '0;
            s1    <= 1'b0;
            d_s   <= 1'b0;
            pre   <= '0;
            tcnt  <= '0;
            calm  <= '0;
        end else begin
            s1    <= danger;
            d_s   <= s1;
            state <= next;
            pre   <= (next != state || tick) ? '0 : pre + TW'(1);
            tcnt  <= next != state ? '0 : tick ? tcnt + TW'(1) : tcnt;
            calm  <= (state != SENSE || d_s || calm_hit) ? '0 : tick ? calm + TW'(1) : calm;
            if (state == SENSE && d_s && round < NR)
                round <= round + 4'd1;
            else if ((state == RECOVER && next == SENSE) || (state == SENSE && !d_s && calm_hit))
                round <= '0;
        end
    end

    assign out_state = state;
    assign back      = state == RETREAT;
    assign sting     = state == ATTACK || state == DART;
    assign busy      = state != SENSE;
endmodule

// File: tb/tb_scorpion_param.sv
// tb_scorpion_param: directed scenarios for scorpion_param with the small test timing set
// (tick = 4 clocks, RETREAT 8, WAIT 4, ATTACK 8, DART 4, RECOVER 12 clocks, calm after 5 ticks).
module tb_scorpion_param;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       danger = 1'b0;
    logic [3:0] out_state, round;
    logic       back, sting, busy;
    int         asserts = 0;
    int         failures = 0;

    scorpion_param #(
        .TICK_DIV(4), .N_RETREAT(2), .RETREAT_T(2), .WAIT_T(1),
        .ATTACK_T(2), .DART_T(1), .RECOVER_T(3), .CALM_T(5), .TW(16)
    ) dut (
        .clk(clk), .reset(reset), .danger(danger), .out_state(out_state),
        .round(round), .back(back), .sting(sting), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        danger = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        asserts++;
        if (out_state !== 4'd0 || round !== 4'd0 || busy !== 1'b0 || back !== 1'b0 || sting !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got state=%0d round=%0d busy=%b back=%b sting=%b exp all 0",
                     out_state, round, busy, back, sting);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            asserts++;
            if (out_state !== 4'd0 || round !== 4'd0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL idle_quiet i=%0d got state=%0d round=%0d busy=%b exp 0/0/0",
                         i, out_state, round, busy);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] exp_s;
        do_reset();
        danger = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 3) danger = 1'b0;
            exp_s = i < 3 ? 4'd0 : i < 11 ? 4'd1 : i < 15 ? 4'd2 : 4'd0;
            asserts++;
            if (out_state !== exp_s || back !== (exp_s == 4'd1) || busy !== (exp_s != 4'd0)) begin
                failures++;
                $display("FAIL single_state i=%0d got state=%0d back=%b busy=%b exp state=%0d",
                         i, out_state, back, busy, exp_s);
            end
            asserts++;
            if (round !== (i >= 3 ? 4'd1 : 4'd0)) begin
                failures++;
                $display("FAIL single_round i=%0d got %0d exp %0d", i, round, i >= 3 ? 1 : 0);
            end
        end
    endtask

    task automatic test_attack();
        int ss[11] = '{0, 1, 2, 0, 1, 2, 0, 3, 4, 5, 0};
        int sl[11] = '{2, 8, 4, 3, 8, 4, 3, 8, 4, 12, 1};
        int k = 0;
        int left = 2;
        logic [3:0] exp_s;
        do_reset();
        danger = 1'b1;
        for (int i = 1; i <= 57; i++) begin
            @(negedge clk);
            exp_s = 4'(ss[k]);
            asserts++;
            if (out_state !== exp_s || sting !== (exp_s == 4'd3 || exp_s == 4'd4)) begin
                failures++;
                $display("FAIL attack_seq i=%0d got state=%0d sting=%b exp state=%0d", i, out_state, sting, exp_s);
            end
            if (i == 33) begin
                asserts++;
                if (round !== 4'd2) begin
                    failures++;
                    $display("FAIL attack_round_sat got %0d exp 2", round);
                end
            end
            if (i == 57) begin
                asserts++;
                if (round !== 4'd0) begin
                    failures++;
                    $display("FAIL recover_clears_round got %0d exp 0", round);
                end
            end
            left = left - 1;
            if (left == 0 && k < 10) begin
                k = k + 1;
                left = sl[k];
            end
            danger = i < 3 || (i >= 15 && i < 18) || (i >= 30 && i < 33);
        end
    endtask

    task automatic test_calm();
        for (int run = 0; run < 2; run++) begin
            do_reset();
            danger = 1'b1;
            for (int i = 1; i <= 36; i++) begin
                @(negedge clk);
                if (i == 3 || i == 35) danger = 1'b0;
                if (run == 1 && i == 32) danger = 1'b1;
                if (i == 15 || i == 34) begin
                    asserts++;
                    if (out_state !== 4'd0 || round !== 4'd1) begin
                        failures++;
                        $display("FAIL calm_pre run=%0d i=%0d got state=%0d round=%0d exp 0/1",
                                 run, i, out_state, round);
                    end
                end
                if (i == 35) begin
                    asserts++;
                    if (out_state !== (run == 1 ? 4'd1 : 4'd0) || round !== (run == 1 ? 4'd2 : 4'd0)) begin
                        failures++;
                        $display("FAIL calm_edge run=%0d got state=%0d round=%0d exp %0d/%0d",
                                 run, out_state, round, run, run * 2);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ss[12] = '{0, 1, 2, 0, 1, 2, 0, 3, 4, 5, 0, 1};
        int sl[12] = '{2, 8, 4, 1, 8, 4, 1, 8, 4, 12, 1, 1};
        int k = 0;
        int left = 2;
        logic [3:0] exp_s;
        do_reset();
        danger = 1'b1;
        for (int i = 1; i <= 54; i++) begin
            @(negedge clk);
            exp_s = 4'(ss[k]);
            asserts++;
            if (out_state !== exp_s || busy !== (exp_s != 4'd0)) begin
                failures++;
                $display("FAIL held_seq i=%0d got state=%0d busy=%b exp state=%0d", i, out_state, busy, exp_s);
            end
            left = left - 1;
            if (left == 0 && k < 11) begin
                k = k + 1;
                left = sl[k];
            end
        end
        asserts++;
        if (round !== 4'd1) begin
            failures++;
            $display("FAIL held_round got %0d exp 1", round);
        end
        danger = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        danger = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk);
            if (i == 29) begin
                danger = 1'b0;
                asserts++;
                if (out_state !== 4'd3) begin
                    failures++;
                    $display("FAIL mid_reach_attack got %0d exp 3", out_state);
                end
            end
        end
        #2 reset = 1'b1;
        #1;
        asserts++;
        if (out_state !== 4'd0 || sting !== 1'b0 || busy !== 1'b0 || round !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset got state=%0d sting=%b busy=%b round=%0d exp 0/0/0/0",
                     out_state, sting, busy, round);
        end
        @(negedge clk);
        reset = 1'b0;
        danger = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            asserts++;
            if (out_state !== (i == 3 ? 4'd1 : 4'd0) || round !== (i == 3 ? 4'd1 : 4'd0)) begin
                failures++;
                $display("FAIL mid_after i=%0d got state=%0d round=%0d exp %0d/%0d",
                         i, out_state, round, i == 3 ? 1 : 0, i == 3 ? 1 : 0);
            end
        end
        danger = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_attack();
        test_calm();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
